// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, frame shape and
// default bus window / baud settings.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    localparam int          CLKS_PER_BIT_DEF = 104;
    localparam logic [31:0] ADR_LL_DEF       = 32'h00D0_0000;
    localparam logic [31:0] ADR_UL_DEF       = 32'h00D1_0000;

endpackage

// File: rtl/tx_bit_serializer.sv
// 8N1 serializer: accepts a byte on i_load while o_ready and shifts it out
// LSB first with one start and one stop bit.
module tx_bit_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic [DATA_BITS-1:0] i_byte,
    output logic                 o_ready,
    output logic                 o_last,
    output logic                 o_tx
);

    localparam int             TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  T_LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_DATA = 3'(FRAME_BITS - 3);

    state_e                phase_q, phase_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [2:0]            bit_q, bit_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic                  bit_end;

    assign bit_end = (timer_q == T_LAST);
    // o_last marks the final stop-bit cycle so the next byte can follow with no gap
    assign o_last  = (phase_q == ST_STOP) && bit_end;
    assign o_ready = (phase_q == ST_IDLE) || o_last;
    assign o_tx    = tx_q;

    always_comb begin
        phase_d = phase_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        timer_d = (phase_q == ST_IDLE || bit_end) ? '0 : timer_q + 1'b1;
        case (phase_q)
            ST_START: if (bit_end) begin
                phase_d = ST_DATA;
                bit_d   = 3'd0;
            end
            ST_DATA: if (bit_end) begin
                shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
                if (bit_q == LAST_DATA) phase_d = ST_STOP;
                else                    bit_d   = bit_q + 3'd1;
            end
            ST_STOP: if (bit_end) phase_d = ST_IDLE;
            default: phase_d = ST_IDLE;
        endcase
        if (i_load && o_ready) begin
            phase_d = ST_START;
            timer_d = '0;
            bit_d   = 3'd0;
            shreg_d = i_byte;
        end
        case (phase_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_q <= ST_IDLE;
            timer_q <= '0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
        end else begin
            phase_q <= phase_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge i_clk) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: rtl/ram_uart_tx.sv
// Wishbone-read UART transmitter: fetches a byte buffer from RAM word by word
// and sends the bytes little-endian, back to back, through tx_bit_serializer.
module ram_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter logic [31:0] ADR_LL       = ADR_LL_DEF,
    parameter logic [31:0] ADR_UL       = ADR_UL_DEF
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_start,
    input  logic [15:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_wb_adr,
    output logic        o_wb_cyc,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_tx
);

    state_e       state_q, state_d;
    logic [31:0]  adr_q, adr_d;
    logic [15:0]  rem_q, rem_d;
    logic [1:0]   lane_q, lane_d;
    logic [31:0]  word_q, word_d;
    logic         ser_load, ser_ready, ser_last;
    logic [7:0]   ser_byte;

    function automatic logic [31:0] next_adr(input logic [31:0] adr);
        logic [32:0] sum;
        sum = {1'b0, adr} + 33'd4;
        if (sum >= {1'b0, ADR_UL}) return ADR_LL;
        return sum[31:0];
    endfunction

    assign o_busy   = (state_q == ST_FETCH) || (state_q == ST_START);
    assign o_done   = (state_q == ST_DONE);
    assign o_wb_cyc = (state_q == ST_FETCH);
    assign o_wb_adr = adr_q;
    assign o_wb_we  = 1'b0;
    assign o_wb_sel = 4'b1111;

    // ST_START here means "a frame is on the line"; the serializer tracks START/DATA/STOP
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        rem_d    = rem_q;
        lane_d   = lane_q;
        word_d   = word_q;
        ser_load = 1'b0;
        ser_byte = word_q[{lane_q, 3'b000} +: 8];
        case (state_q)
            ST_IDLE: if (i_start) begin
                if (i_len != 16'd0) begin
                    rem_d   = i_len;
                    adr_d   = ADR_LL;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_FETCH: if (i_wb_ack && ser_ready) begin
                word_d   = i_wb_rdt;
                lane_d   = 2'd0;
                ser_load = 1'b1;
                ser_byte = i_wb_rdt[7:0];
                state_d  = ST_START;
            end
            ST_START: if (ser_last) begin
                rem_d = (rem_q != 16'd0) ? rem_q - 16'd1 : 16'd0;
                if (rem_q <= 16'd1) begin
                    state_d = ST_DONE;
                end else if (lane_q != 2'd3) begin
                    lane_d   = lane_q + 2'd1;
                    ser_load = 1'b1;
                    ser_byte = word_q[{lane_d, 3'b000} +: 8];
                end else begin
                    adr_d   = next_adr(adr_q);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q <= ST_IDLE;
            adr_q   <= ADR_LL;
            rem_q   <= 16'd0;
            lane_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            lane_q  <= lane_d;
        end
    end

    always_ff @(posedge i_wb_clk) begin
        word_q <= word_d;
    end

    tx_bit_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .i_clk   (i_wb_clk),
        .i_rst   (i_wb_rst),
        .i_load  (ser_load),
        .i_byte  (ser_byte),
        .o_ready (ser_ready),
        .o_last  (ser_last),
        .o_tx    (o_tx)
    );

endmodule

// File: tb/tb_ram_uart_tx.sv
// Bench for ram_uart_tx: a two-word RAM window, a UART line decoder and a
// byte/timing reference model derived from the buffer contents and length.
module tb_ram_uart_tx;

    localparam int          CPB = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] LL  = 32'h00D0_0000;
    localparam logic [31:0] UL  = LL + 32'd8;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] len;
    logic        busy, done, cyc, we, tx;
    logic [31:0] adr, rdt, widx;
    logic [3:0]  sel;
    logic        ack = 1'b0;
    logic [31:0] mem [0:1];

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;

    ram_uart_tx #(.CLKS_PER_BIT(CPB), .ADR_LL(LL), .ADR_UL(UL)) dut (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_start(start), .i_len(len),
        .o_busy(busy), .o_done(done), .o_wb_adr(adr), .o_wb_cyc(cyc),
        .o_wb_we(we), .o_wb_sel(sel), .i_wb_rdt(rdt), .i_wb_ack(ack), .o_tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // RAM acknowledges one cycle after cyc rises
    assign widx = (adr - LL) >> 2;
    assign rdt  = (widx < 32'd2) ? mem[widx[0]] : 32'hDEAD_BEEF;
    always @(posedge clk) ack <= rst ? 1'b0 : (cyc && !ack);

    logic [7:0]  rx_q[$];
    int          rx_start_q[$];
    int          done_q[$];
    int          cyc_rise_q[$];
    logic [31:0] fetch_q[$];
    int          busy_cycles = 0, tx_low_cycles = 0, framing_err = 0;
    bit          rx_active = 0;
    logic        prev_cyc = 1'b0;
    int          rx_st, k;
    logic [7:0]  rx_sh;

    initial begin
        forever begin
            @(negedge clk);
            if (done) done_q.push_back(cyc_cnt);
            if (cyc && ack) fetch_q.push_back(adr);
            if (cyc && !prev_cyc) cyc_rise_q.push_back(cyc_cnt);
            prev_cyc = cyc;
            if (busy) busy_cycles++;
            if (!tx) tx_low_cycles++;
            if (rst) begin
                rx_active = 0;
            end else if (!rx_active) begin
                if (!tx) begin
                    rx_active = 1;
                    rx_st = cyc_cnt;
                    rx_start_q.push_back(cyc_cnt);
                end
            end else begin
                k = cyc_cnt - rx_st;
                if (k == CPB / 2 && tx) framing_err++;
                if (k > CPB && k < 9 * CPB && (k - CPB / 2) % CPB == 0) rx_sh = {tx, rx_sh[7:1]};
                if (k == 9 * CPB + CPB / 2) begin
                    if (!tx) framing_err++;
                    rx_q.push_back(rx_sh);
                    rx_active = 0;
                end
            end
        end
    end

    // Byte i of a transfer: little-endian lanes, words cycling through the 2-word window
    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = mem[(i / 4) % 2];
        return w[8 * (i % 4) +: 8];
    endfunction

    function automatic int exp_done(input int t0, input int n);
        return t0 + 1 + 2 * ((n + 3) / 4) + FRAME * n;
    endfunction

    task automatic clear_mon();
        rx_q.delete(); rx_start_q.delete(); done_q.delete();
        cyc_rise_q.delete(); fetch_q.delete();
        framing_err = 0;
    endtask

    task automatic do_start(input logic [15:0] l, output int t0);
        @(posedge clk); #1;
        start = 1'b1; len = l; t0 = cyc_cnt;
        @(posedge clk); #1;
        start = 1'b0; len = 16'($urandom);
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        int c = 0;
        while (done_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (done_q.size() >= n);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stream(input string name, input int t0, input int n, input bit ok);
        logic [7:0] got;
        int nd;
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_timeout: no o_done seen", name); end
        checks++;
        if (rx_q.size() != n) begin
            failures++; $display("FAIL %s_count: got %0d bytes, want %0d", name, rx_q.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            got = 8'hxx;
            if (i < rx_q.size()) got = rx_q[i];
            checks++;
            if (got !== exp_byte(i)) begin
                failures++; $display("FAIL %s_byte%0d: got %h want %h", name, i, got, exp_byte(i));
            end
        end
        nd = (done_q.size() > 0) ? done_q[0] : -1;
        checks++;
        if (nd != exp_done(t0, n)) begin
            failures++; $display("FAIL %s_done_time: got %0d want %0d", name, nd, exp_done(t0, n));
        end
        checks++;
        if (fetch_q.size() != (n + 3) / 4 || framing_err != 0) begin
            failures++;
            $display("FAIL %s_fetch_frame: fetches %0d want %0d, framing errors %0d want 0",
                     name, fetch_q.size(), (n + 3) / 4, framing_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || cyc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl: tx=%b cyc=%b busy=%b done=%b want 1 0 0 0", tx, cyc, busy, done);
        end
        checks++;
        if (adr !== LL) begin failures++; $display("FAIL reset_adr: got %h want %h", adr, LL); end
        checks++;
        if (we !== 1'b0 || sel !== 4'hF) begin
            failures++; $display("FAIL reset_we_sel: we=%b sel=%h want 0 f", we, sel);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_len3();
        int t0; bit ok; int rise;
        mem[0] = 32'h4433_2211; mem[1] = $urandom;
        clear_mon();
        busy_cycles = 0;
        do_start(16'd3, t0);
        wait_done(1, 400, ok);
        check_stream("len3", t0, 3, ok);
        rise = (cyc_rise_q.size() > 0) ? cyc_rise_q[0] : -1;
        checks++;
        if (rise != t0 + 1) begin failures++; $display("FAIL len3_cyc_rise: got %0d want %0d", rise, t0 + 1); end
        checks++;
        if ((rx_start_q.size() > 0 ? rx_start_q[0] : -1) != t0 + 3) begin
            failures++; $display("FAIL len3_first_start: got %0d want %0d",
                                 rx_start_q.size() > 0 ? rx_start_q[0] : -1, t0 + 3);
        end
        checks++;
        if (busy_cycles != 122) begin failures++; $display("FAIL len3_busy_span: got %0d want 122", busy_cycles); end
    endtask

    task automatic test_len6();
        int t0; bit ok; int gap;
        mem[0] = 32'hDDCC_BBAA; mem[1] = 32'h0000_FFEE;
        clear_mon();
        do_start(16'd6, t0);
        wait_done(1, 600, ok);
        check_stream("len6", t0, 6, ok);
        gap = (rx_start_q.size() > 4) ? rx_start_q[4] - rx_start_q[3] : -1;
        checks++;
        if (gap != FRAME + 2) begin failures++; $display("FAIL len6_word_gap: got %0d want %0d", gap, FRAME + 2); end
        checks++;
        if (fetch_q.size() != 2 || fetch_q[0] !== LL || fetch_q[1] !== LL + 32'd4) begin
            failures++; $display("FAIL len6_fetch_adr: count %0d, want %h %h", fetch_q.size(), LL, LL + 32'd4);
        end
    endtask

    task automatic test_wrap();
        int t0; bit ok;
        mem[0] = $urandom; mem[1] = $urandom;
        clear_mon();
        do_start(16'd12, t0);
        wait_done(1, 900, ok);
        check_stream("wrap", t0, 12, ok);
        checks++;
        if (fetch_q.size() != 3 || fetch_q[2] !== LL) begin
            failures++; $display("FAIL wrap_third_adr: count %0d, want third fetch at %h", fetch_q.size(), LL);
        end
    endtask

    task automatic test_len0();
        int t0; int b0, l0; int nd;
        clear_mon();
        b0 = busy_cycles; l0 = tx_low_cycles;
        do_start(16'd0, t0);
        repeat (10) @(negedge clk);
        nd = (done_q.size() > 0) ? done_q[0] : -1;
        checks++;
        if (done_q.size() != 1 || nd != t0 + 1) begin
            failures++; $display("FAIL len0_done: count %0d at %0d, want 1 at %0d", done_q.size(), nd, t0 + 1);
        end
        checks++;
        if (cyc_rise_q.size() != 0 || busy_cycles != b0) begin
            failures++; $display("FAIL len0_no_bus: cyc rises %0d busy cycles %0d, want 0 0",
                                 cyc_rise_q.size(), busy_cycles - b0);
        end
        checks++;
        if (tx_low_cycles != l0) begin failures++; $display("FAIL len0_tx_idle: low cycles %0d want 0", tx_low_cycles - l0); end
    endtask

    task automatic test_ignore_start();
        int t0; bit ok; int n;
        n = $urandom_range(2, 7);
        mem[0] = $urandom; mem[1] = $urandom;
        clear_mon();
        do_start(16'(n), t0);
        repeat (8) @(posedge clk);
        #1; start = 1'b1; len = 16'd5;
        @(posedge clk); #1; start = 1'b0;
        wait_done(1, 700, ok);
        repeat (300) @(negedge clk);
        check_stream("ignore", t0, n, ok);
        checks++;
        if (done_q.size() != 1) begin failures++; $display("FAIL ignore_done_count: got %0d want 1", done_q.size()); end
    endtask

    task automatic test_reset_mid();
        int t0; bit ok;
        mem[0] = $urandom; mem[1] = $urandom;
        clear_mon();
        do_start(16'd4, t0);
        while (cyc_cnt < t0 + 3 + 3 * CPB + 1) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || cyc !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midreset_abort: tx=%b cyc=%b busy=%b want 1 0 0", tx, cyc, busy);
        end
        checks++;
        if (done_q.size() != 0) begin failures++; $display("FAIL midreset_no_done: got %0d want 0", done_q.size()); end
        repeat (3) @(posedge clk);
        mem[0] = $urandom;
        clear_mon();
        do_start(16'd4, t0);
        wait_done(1, 400, ok);
        check_stream("after_reset", t0, 4, ok);
        checks++;
        if (fetch_q.size() < 1 || fetch_q[0] !== LL) begin
            failures++; $display("FAIL after_reset_adr: first fetch not at %h", LL);
        end
    endtask

    task automatic test_random();
        int t0; bit ok; int n;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 10);
            mem[0] = $urandom; mem[1] = $urandom;
            clear_mon();
            do_start(16'(n), t0);
            wait_done(1, 1000, ok);
            check_stream($sformatf("rand%0d", it), t0, n, ok);
        end
    endtask

    initial begin
        mem[0] = 32'h0; mem[1] = 32'h0;
        test_reset();
        test_len3();
        test_len6();
        test_wrap();
        test_len0();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_uart_tx.md
# ram_uart_tx

Wishbone-master transmit engine for the UART link: on a start command it reads a byte buffer out of shared RAM word by word and serializes the bytes, LSB-first 8N1, onto a UART TX line. It is the transmit counterpart of the RX path that writes received bytes into a RAM window. It sits beside the CPU on the memory bus and needs an external arbiter for the RAM port.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200).
- `ADR_LL`, default 'h00D00000: first byte address of the TX buffer window; word aligned.
- `ADR_UL`, default 'h00D10000: exclusive upper bound of the window; word aligned; must be greater than `ADR_LL`.
- `i_wb_clk` in 1: the single clock.
- `i_wb_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: one-cycle command pulse. Sampled only in IDLE.
- `i_len` in 16: byte count for the command, sampled with `i_start`.
- `o_busy` out 1: high from the cycle after an accepted start until `o_done`.
- `o_done` out 1: one-cycle completion pulse.
- `o_wb_adr` out 32: read address, always word aligned.
- `o_wb_cyc` out 1: bus request.
- `o_wb_we` out 1: constant 0.
- `o_wb_sel` out 4: constant 4'b1111.
- `i_wb_rdt` in 32: read data.
- `i_wb_ack` in 1: read acknowledge. Ignored while `o_wb_cyc` is 0.
- `o_tx` out 1: serial line, idle high.

## Operation
- Reset values: `o_tx`=1, `o_wb_cyc`=0, `o_wb_adr`=`ADR_LL`, `o_busy`=0, `o_done`=0. The FSM goes to IDLE.
- A reset in the middle of a fetch or frame aborts it. `o_tx` returns high on the next cycle and the truncated frame is not resumed.
- FSM states: IDLE, FETCH, START, DATA, STOP, DONE.
- IDLE:
  - With `i_start`=1 and `i_len`≠0: latch the remaining count = `i_len`, set address = `ADR_LL`, go to FETCH.
  - With `i_start`=1 and `i_len`=0: go to DONE. No bus access, `o_tx` stays high.
- FETCH:
  - Hold `o_wb_cyc`=1 and a stable `o_wb_adr` until `i_wb_ack`.
  - On ack, latch `i_wb_rdt` into the word register and set the byte lane to 0.
  - Next state is START; `o_wb_cyc` drops in that cycle.
- START: `o_tx`=0 for `CLKS_PER_BIT` cycles. The current byte is `word[8*lane +: 8]` (little-endian lanes).
- DATA: 8 bits, LSB first, `CLKS_PER_BIT` cycles each. The bit index counter runs 0..7.
- STOP: `o_tx`=1 for `CLKS_PER_BIT` cycles; decrement the remaining count. On the last STOP cycle:
  - remaining = 0 → DONE.
  - else lane < 3 → lane+1, START (bytes back to back, no idle gap).
  - else lane = 3 → advance the address, go to FETCH.
- DONE: `o_done`=1 for one cycle, `o_busy`=0, then IDLE.
- Address advance: next = `adr+4`. If `adr+4` ≥ `ADR_UL`, next = `ADR_LL` (the buffer wraps).
- Lengths that are not a multiple of 4: unused upper lanes of the final word are never transmitted.
- `i_start` while busy is ignored and not queued. `i_len` changes after acceptance have no effect.
- Bit timer: counts 0..`CLKS_PER_BIT`-1 and is wide enough for `$clog2(CLKS_PER_BIT)`. The remaining-byte counter is 16 bits and never underflows.

## Timing
- Start accepted in cycle T: `o_busy` and `o_wb_cyc` are high in T+1.
- Ack in cycle A: the first start-bit cycle is A+1.
- Each frame is exactly 10·`CLKS_PER_BIT` cycles.
- For N bytes inside one word with the first start bit at S: `o_done` is at S + 10·N·`CLKS_PER_BIT`.
- Between words, `o_tx` stays high for the fetch duration: (ack latency + 1) cycles.
- `i_len`=0 accepted at T: `o_done` at T+1, `o_busy` never asserted.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum.
  - Frame constants: `DATA_BITS`=8, `FRAME_BITS`=10.
  - Default `CLKS_PER_BIT`.
  - TX window defaults `ADR_LL`/`ADR_UL`.
- Sub-module `tx_bit_serializer`:
  - Takes a byte plus a load strobe; returns a ready flag and `o_tx`.
  - Owns the bit timer, the bit index and the START/DATA/STOP handling.
  - The top level keeps IDLE/FETCH/DONE, the lane, the address and the remaining count.

## Test plan
Bench setting: `CLKS_PER_BIT`=4; the RAM model acks one cycle after `cyc` rises.
- RAM[`ADR_LL`]=32'h44332211, start with `i_len`=3 at T0:
  - `o_wb_cyc` rises at T0+1.
  - Bytes 11, 22, 33 go out back to back on `o_tx`.
  - `o_done` at T0+3+120; lane 3 (0x44) is never sent.
- `i_len`=6 with RAM words 32'hDDCCBBAA and 32'h0000FFEE: sends AA BB CC DD EE FF, with exactly 2 fetches and an idle-high gap between DD and EE.
- `ADR_UL`=`ADR_LL`+8, `i_len`=12: the third fetch address equals `ADR_LL` (wrap) and the bytes repeat the first word.
- `i_len`=0: `o_done` at T0+1, no `o_wb_cyc`, `o_tx` stays high.
- A second `i_start` with `i_len`=5 during the first frame is ignored: total bytes sent equals the first length and there is exactly one `o_done`.
- Assert `i_wb_rst` in the middle of a DATA bit: `o_tx`=1 and `o_wb_cyc`=0 next cycle. A new start then transmits correctly from `ADR_LL`.
